ofmap_collector: RTL and testbench



---
 rtl/ofmap_collector_if.sv | 40 ++++
 rtl/ofmap_collector.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_ofmap_collector.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofmap_collector_if.sv
// rtl/ofmap_collector_if.sv - handshake/bus bundle between the DSP array, the collector and the DDR writer
//
// Purpose: groups every non-clock signal of ofmap_collector.
// Ports (slave view, i.e. the collector):
//   dshape    in   {w,h,c} frame shape, sampled on start
//   clr       in   synchronous abort
//   start     in   begin a frame
//   in_valid  in   / in_ready out : DSP result beat handshake, di carries N_DSP lane words
//   out_valid out  / out_ready in : output word handshake, dout + cur_coord {c,y,x}
//   done      out  frame complete (level)
//   err       out  shape rejected (level)
interface ofmap_collector_if #(
  parameter int N_DSP      = 3,
  parameter int B_DSHAPE   = 48,
  parameter int B_COORD    = 8,
  parameter int DATA_WIDTH = 64
);
  logic [B_DSHAPE-1:0]         dshape;
  logic                        clr;
  logic                        start;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH*N_DSP-1:0] di;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH-1:0]       dout;
  logic [3*B_COORD-1:0]        cur_coord;
  logic                        done;
  logic                        err;

  modport master (
    output dshape, clr, start, in_valid, di, out_ready,
    input  in_ready, out_valid, dout, cur_coord, done, err
  );

  modport slave (
    input  dshape, clr, start, in_valid, di, out_ready,
    output in_ready, out_valid, dout, cur_coord, done, err
  );
endinterface

// File: rtl/ofmap_collector.sv
// rtl/ofmap_collector.sv - collects N_DSP-lane result beats into banks and drains them in c,y,x order
//
// Purpose: each group of N_DSP output columns is written lane-per-bank (FILL), then
// the banks are read back one after another as a single word stream (DRAIN).
// Ports:
//   clk   in  clock
//   rstn  in  asynchronous active-low reset
//   bus   ofmap_collector_if.slave (shape/control, input beats, output words, status)
module ofmap_collector #(
  parameter int N_DSP      = 3,
  parameter int B_BUF_ADDR = 9,
  parameter int B_DSHAPE   = 48,
  parameter int B_COORD    = 8,
  parameter int DATA_WIDTH = 64
) (
  input logic clk,
  input logic rstn,
  ofmap_collector_if.slave bus
);
  localparam int DEPTH = 1 << B_BUF_ADDR;
  localparam int BW    = (N_DSP > 1) ? $clog2(N_DSP) : 1;
  localparam int AW1   = B_BUF_ADDR + 1;  // one extra bit so a full bank (D == DEPTH) is countable
  localparam int CW    = 3 * B_COORD;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

  // shape decode
  logic [15:0] sh_w, sh_h;
  logic [9:0]  sh_nwc;
  logic [25:0] sh_dep;
  logic        unused_dshape;
  assign sh_w   = bus.dshape[B_DSHAPE-1 -: 16];
  assign sh_h   = bus.dshape[B_DSHAPE-17 -: 16];
  assign sh_nwc = bus.dshape[B_DSHAPE-33 -: 10];
  assign sh_dep = sh_nwc * sh_h;
  assign unused_dshape = ^bus.dshape[B_DSHAPE-43:0];

  state_t          state_q, state_d;
  logic [9:0]      nwc_q, nwc_d;
  logic [15:0]     w_q, w_d;
  logic [AW1-1:0]  dep_q, dep_d;
  logic [15:0]     x0_q, x0_d;
  logic            in_ready_q, in_ready_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [AW1-1:0]  waddr_q, waddr_d;
  // drain read-issue side
  logic [AW1-1:0]  raddr_q, raddr_d;
  logic [BW-1:0]   rbank_q, rbank_d;
  logic [15:0]     rc_q, rc_d, ry_q, ry_d;
  logic            rdone_q, rdone_d;
  // read in flight (bank output valid next cycle)
  logic            pend_q, pend_d;
  logic [BW-1:0]   pbank_q, pbank_d;
  logic [CW-1:0]   pcoord_q, pcoord_d;
  // 2-entry output skid, slot 0 is what dout shows
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] s0_data_q, s0_data_d, s1_data_q, s1_data_d;
  logic [CW-1:0]         s0_coord_q, s0_coord_d, s1_coord_q, s1_coord_d;

  logic [N_DSP-1:0]            we;
  logic                        rd_en;
  logic [N_DSP*DATA_WIDTH-1:0] rdata_flat;
  logic [DATA_WIDTH-1:0]       push_data;

  for (genvar j = 0; j < N_DSP; j++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (we[j]) mem[waddr_q[B_BUF_ADDR-1:0]] <= bus.di[j*DATA_WIDTH +: DATA_WIDTH];
      if (rd_en && (rbank_q == BW'(j))) rd_q <= mem[raddr_q[B_BUF_ADDR-1:0]];
    end
    assign rdata_flat[j*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

  assign push_data = rdata_flat[int'(pbank_q)*DATA_WIDTH +: DATA_WIDTH];

  logic       beat, pop, last_bank;
  logic [1:0] eff;
  logic [2:0] occ;
  logic [15:0] xsum;

  assign beat = (state_q == S_FILL) && in_ready_q && bus.in_valid;
  assign pop  = (cnt_q != 2'd0) && bus.out_ready;
  assign eff  = cnt_q - {1'b0, pop};
  // occupancy the skid will hold once the in-flight read lands; a new read is
  // only issued if its word is guaranteed a slot even if nothing drains meanwhile
  assign occ  = 3'(eff) + 3'(pend_q);
  assign rd_en = (state_q == S_DRAIN) && !rdone_q && (occ <= 3'd1);
  assign last_bank = (rbank_q == BW'(N_DSP - 1)) ||
                     (({1'b0, x0_q} + 17'(rbank_q) + 17'd1) >= {1'b0, w_q});
  assign xsum = x0_q + 16'(rbank_q);

  always_comb begin
    state_d    = state_q;
    nwc_d      = nwc_q;
    w_d        = w_q;
    dep_d      = dep_q;
    x0_d       = x0_q;
    in_ready_d = in_ready_q;
    done_d     = done_q;
    err_d      = err_q;
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    rbank_d    = rbank_q;
    rc_d       = rc_q;
    ry_d       = ry_q;
    rdone_d    = rdone_q;
    pend_d     = 1'b0;
    pbank_d    = pbank_q;
    pcoord_d   = pcoord_q;
    s0_data_d  = s0_data_q;
    s1_data_d  = s1_data_q;
    s0_coord_d = s0_coord_q;
    s1_coord_d = s1_coord_q;
    we         = '0;

    // lanes beyond the frame width are dropped but the beat still counts
    for (int j = 0; j < N_DSP; j++) begin
      we[j] = beat && (({1'b0, x0_q} + 17'(j)) < {1'b0, w_q});
    end

    // skid buffer: pop shifts slot 1 forward, returning read fills the first free slot
    if (pop) begin
      s0_data_d  = s1_data_q;
      s0_coord_d = s1_coord_q;
    end
    if (pend_q) begin
      if (eff == 2'd0) begin
        s0_data_d  = push_data;
        s0_coord_d = pcoord_q;
      end else begin
        s1_data_d  = push_data;
        s1_coord_d = pcoord_q;
      end
    end
    cnt_d = eff + {1'b0, pend_q};

    if (rd_en) begin
      pend_d   = 1'b1;
      pbank_d  = rbank_q;
      pcoord_d = {rc_q[B_COORD-1:0], ry_q[B_COORD-1:0], xsum[B_COORD-1:0]};
      raddr_d  = raddr_q + AW1'(1);
      rc_d     = rc_q + 16'd1;
      if ((rc_q + 16'd1) == {6'd0, nwc_q}) begin
        rc_d = 16'd0;
        ry_d = ry_q + 16'd1;
      end
      if ((raddr_q + AW1'(1)) == dep_q) begin
        raddr_d = '0;
        rc_d    = 16'd0;
        ry_d    = 16'd0;
        if (last_bank) rdone_d = 1'b1;
        else           rbank_d = rbank_q + BW'(1);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          nwc_d   = sh_nwc;
          w_d     = sh_w;
          x0_d    = 16'd0;
          waddr_d = '0;
          if (sh_dep > 26'(DEPTH)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            done_d  = 1'b0;
          end else if ((sh_nwc == 10'd0) || (sh_h == 16'd0) || (sh_w == 16'd0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d    = S_FILL;
            in_ready_d = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            dep_d      = sh_dep[AW1-1:0];
          end
        end
      end
      S_FILL: begin
        if (beat) begin
          waddr_d = waddr_q + AW1'(1);
          if ((waddr_q + AW1'(1)) == dep_q) begin
            state_d    = S_DRAIN;
            in_ready_d = 1'b0;
            raddr_d    = '0;
            rbank_d    = '0;
            rc_d       = 16'd0;
            ry_d       = 16'd0;
            rdone_d    = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        // final word of the group leaves the skid this cycle
        if (pop && (cnt_q == 2'd1) && !pend_q && rdone_q) begin
          x0_d = x0_q + 16'(N_DSP);
          if (({1'b0, x0_q} + 17'(N_DSP)) >= {1'b0, w_q}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_FILL;
            in_ready_d = 1'b1;
            waddr_d    = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.clr) begin
      state_d    = S_IDLE;
      x0_d       = 16'd0;
      in_ready_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      waddr_d    = '0;
      raddr_d    = '0;
      rbank_d    = '0;
      rc_d       = 16'd0;
      ry_d       = 16'd0;
      rdone_d    = 1'b0;
      pend_d     = 1'b0;
      cnt_d      = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      nwc_q      <= '0;
      w_q        <= '0;
      dep_q      <= '0;
      x0_q       <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      rbank_q    <= '0;
      rc_q       <= '0;
      ry_q       <= '0;
      rdone_q    <= 1'b0;
      pend_q     <= 1'b0;
      pbank_q    <= '0;
      pcoord_q   <= '0;
      cnt_q      <= 2'd0;
      s0_data_q  <= '0;
      s1_data_q  <= '0;
      s0_coord_q <= '0;
      s1_coord_q <= '0;
    end else begin
      state_q    <= state_d;
      nwc_q      <= nwc_d;
      w_q        <= w_d;
      dep_q      <= dep_d;
      x0_q       <= x0_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      rbank_q    <= rbank_d;
      rc_q       <= rc_d;
      ry_q       <= ry_d;
      rdone_q    <= rdone_d;
      pend_q     <= pend_d;
      pbank_q    <= pbank_d;
      pcoord_q   <= pcoord_d;
      cnt_q      <= cnt_d;
      s0_data_q  <= s0_data_d;
      s1_data_q  <= s1_data_d;
      s0_coord_q <= s0_coord_d;
      s1_coord_q <= s1_coord_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.dout      = s0_data_q;
  assign bus.cur_coord = s0_coord_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ofmap_collector.sv
// tb/tb_ofmap_collector.sv - scoreboard bench for ofmap_collector with a pixel-order reference model
module tb_ofmap_collector;
  localparam int N_DSP = 3;
  localparam int B_BUF_ADDR = 9;
  localparam int B_DSHAPE = 48;
  localparam int B_COORD = 8;
  localparam int DW = 64;
  localparam int LIMIT = 4000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  initial forever #5 clk = ~clk;

  ofmap_collector_if #(.N_DSP(N_DSP), .B_DSHAPE(B_DSHAPE), .B_COORD(B_COORD), .DATA_WIDTH(DW)) bus ();

  ofmap_collector #(
    .N_DSP(N_DSP), .B_BUF_ADDR(B_BUF_ADDR), .B_DSHAPE(B_DSHAPE),
    .B_COORD(B_COORD), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  typedef struct packed {
    logic [DW-1:0]        data;
    logic [3*B_COORD-1:0] coord;
  } word_t;

  word_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int frame_hs = 0;
  int ready_pct = 100;
  bit abort_flag = 1'b0;
  logic [15:0] salt = 16'h0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] tag(input int x, input int y, input int c);
    return {salt, 16'(x), 16'(y), 16'(c)};
  endfunction

  // output ready generator
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
    end
  end

  // monitor / scoreboard
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_dout;
  logic [3*B_COORD-1:0] prev_coord;
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_dout", bus.dout, prev_dout);
        chk("stall_coord", bus.cur_coord, prev_coord);
      end
      chk("in_out_exclusive", bus.in_ready & bus.out_valid, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got data=%h coord=%h, expected no output", bus.dout, bus.cur_coord);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          chk("dout", bus.dout, e.data);
          chk("cur_coord", bus.cur_coord, e.coord);
        end
        frame_hs++;
        last_hs_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready && !bus.clr;
      prev_dout  = bus.dout;
      prev_coord = bus.cur_coord;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic drive_beats(input int nwc, input int h, input int w, input int max_groups);
    int d;
    int g;
    d = nwc * h;
    g = 0;
    for (int x0 = 0; x0 < w && g < max_groups; x0 += N_DSP) begin
      for (int b = 0; b < d; b++) begin
        int n;
        bit hs;
        n = 0;
        hs = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        for (int j = 0; j < N_DSP; j++) bus.di[j*DW +: DW] = tag(x0 + j, b / nwc, b % nwc);
        bus.in_valid = 1'b1;
        while (!hs && n < LIMIT && !abort_flag) begin
          @(negedge clk);
          hs = bus.in_ready;
          n++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (abort_flag) return;
        if (!hs) begin
          chk("in_ready_timeout", hs, 1);
          return;
        end
      end
      g++;
    end
  endtask

  task automatic do_abort(input int at);
    int n;
    n = 0;
    while (frame_hs < at && n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_reached", frame_hs >= at, 1);
    bus.clr = 1'b1;
    abort_flag = 1'b1;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_err", bus.err, 0);
    exp_q.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_idle_in_ready", bus.in_ready, 0);
      chk("abort_idle_out_valid", bus.out_valid, 0);
    end
  endtask

  // expected stream: x outer, then y, then c fastest
  task automatic run_frame(input int c, input int h, input int w, input int pct, input int abort_at);
    int nwc;
    int n;
    nwc = c / 64;
    salt = 16'($urandom);
    for (int x = 0; x < w; x++)
      for (int y = 0; y < h; y++)
        for (int ci = 0; ci < nwc; ci++) begin
          word_t e;
          e.data  = tag(x, y, ci);
          e.coord = {B_COORD'(ci), B_COORD'(y), B_COORD'(x)};
          exp_q.push_back(e);
        end
    ready_pct = pct;
    frame_hs = 0;
    abort_flag = 1'b0;
    bus.dshape = {16'(w), 16'(h), 16'(c)};
    pulse_start();
    chk("in_ready_after_start", bus.in_ready, 1);
    chk("err_after_start", bus.err, 0);
    chk("done_after_start", bus.done, 0);
    fork
      drive_beats(nwc, h, w, 1000);
      if (abort_at > 0) do_abort(abort_at);
    join
    if (!abort_flag) begin
      n = 0;
      while (!bus.done && n < LIMIT) begin
        @(negedge clk);
        n++;
      end
      chk("done_seen", bus.done, 1);
      chk("done_latency", cyc - last_hs_cyc, 1);
      chk("words_delivered", exp_q.size(), 0);
      chk("word_count", frame_hs, w * h * nwc);
    end
  endtask

  initial begin
    bus.dshape = '0;
    bus.clr = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.di = '0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_cur_coord", bus.cur_coord, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    run_frame(128, 2, 6, 100, 0);   // full groups
    run_frame(128, 2, 4, 100, 0);   // partial last group
    run_frame(128, 2, 6, 30, 0);    // backpressure
    run_frame(128, 2, 6, 70, 5);    // abort after 5th word
    run_frame(128, 2, 6, 100, 0);   // clean frame after abort

    // c=32: no words per pixel
    bus.dshape = {16'd6, 16'd2, 16'd32};
    pulse_start();
    chk("zero_done", bus.done, 1);
    chk("zero_err", bus.err, 0);
    chk("zero_in_ready", bus.in_ready, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("zero_no_in_ready", bus.in_ready, 0);
      chk("zero_no_out", bus.out_valid, 0);
      chk("zero_done_hold", bus.done, 1);
    end

    // depth 600 exceeds the 512-word bank
    bus.dshape = {16'd2, 16'd600, 16'd64};
    pulse_start();
    chk("big_err", bus.err, 1);
    chk("big_done", bus.done, 0);
    chk("big_in_ready", bus.in_ready, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("big_err_hold", bus.err, 1);
      chk("big_stay_idle", bus.in_ready, 0);
    end

    // reset in the middle of FILL
    salt = 16'($urandom);
    bus.dshape = {16'd6, 16'd2, 16'd128};
    pulse_start();
    chk("mid_in_ready", bus.in_ready, 1);
    bus.di = {3{tag(0, 0, 0)}};
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_dout", bus.dout, 0);
    chk("arst_cur_coord", bus.cur_coord, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_err", bus.err, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    run_frame(128, 2, 6, 50, 0);

    // random shapes and ready duty
    repeat (4) begin
      run_frame(64 * $urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(1, 8),
                $urandom_range(40, 100), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1);
  end
endmodule
